// File: rtl/dmem_responder.sv
// Data memory shared between a CPU port (priority, combinational load) and a
// host request/response port, with a sticky CPU address-error flag and a
// saturating committed-write counter.
module dmem_responder #(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              data_addr,
    input  logic [31:0]              data_out,
    output logic [31:0]              data_in,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic                     host_we,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic [31:0]              host_wdata,
    output logic                     host_rvalid,
    output logic [31:0]              host_rdata,
    output logic                     addr_err,
    output logic [15:0]              wr_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e        state_q;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] cpu_idx;
    logic          cpu_legal;
    logic          cpu_wr_commit;
    logic          host_accept;
    logic          host_wr_commit;

    // CPU address decode, host handshake and write-commit qualifiers
    always_comb begin
        cpu_idx        = data_addr[AW+1:2];
        cpu_legal      = (data_addr[1:0] == 2'b00) && (data_addr[31:AW+2] == '0);
        host_ready     = (state_q == StIdle) && !mem_read && !mem_write;
        // No RAM write may happen while reset is held
        cpu_wr_commit  = mem_write && cpu_legal && !rst;
        host_accept    = host_valid && host_ready && !rst;
        host_wr_commit = host_accept && host_we;
        data_in        = (mem_read && cpu_legal) ? mem[cpu_idx] : 32'd0;
    end

    // RAM write port; CPU and host commits are mutually exclusive by host_ready
    always_ff @(posedge clk) begin
        if (cpu_wr_commit) begin
            mem[cpu_idx] <= data_out;
        end else if (host_wr_commit) begin
            mem[host_addr] <= host_wdata;
        end
    end

    // Host FSM with registered response, error flag and write counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            host_rvalid <= 1'b0;
            host_rdata  <= 32'd0;
            addr_err    <= 1'b0;
            wr_count    <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    host_rvalid <= 1'b0;
                    if (host_accept) begin
                        state_q     <= StResp;
                        host_rvalid <= !host_we;
                        if (!host_we) begin
                            host_rdata <= mem[host_addr];
                        end
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    host_rvalid <= 1'b0;
                end
                default: begin
                    state_q     <= StIdle;
                    host_rvalid <= 1'b0;
                end
            endcase
            if ((mem_read || mem_write) && !cpu_legal) begin
                addr_err <= 1'b1;
            end
            if ((cpu_wr_commit || host_wr_commit) && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [5:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        addr_err;
    logic [15:0] wr_count;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_addr  (data_addr),
        .data_out   (data_out),
        .data_in    (data_in),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .addr_err   (addr_err),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        data_addr  = '0;
        data_out   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1;
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", host_rvalid); end
        total++; if (host_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", host_rdata); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        total++; if (data_in !== 32'd0) begin bad++; $display("FAIL reset_data_in got=%h exp=0", data_in); end
        rst = 1'b0;
        tick();
        #1;
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", host_ready); end
    endtask

    task automatic test_host_write();
        host_valid = 1'b1; host_we = 1'b1; host_addr = 6'd11; host_wdata = 32'd12;
        #1;
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL hw_ready got=%b exp=1", host_ready); end
        tick();
        host_valid = 1'b0; host_we = 1'b0;
        #1;
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL hw_resp_ready got=%b exp=0", host_ready); end
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL hw_rvalid got=%b exp=0", host_rvalid); end
        tick();
        mem_read = 1'b1; data_addr = 32'd44;
        #1;
        total++; if (data_in !== 32'd12) begin bad++; $display("FAIL hw_load got=%0d exp=12", data_in); end
        total++; if (wr_count !== 16'd1) begin bad++; $display("FAIL hw_count got=%0d exp=1", wr_count); end
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL hw_cpu_prio got=%b exp=0", host_ready); end
        mem_read = 1'b0;
    endtask

    task automatic test_cpu_priority();
        mem_write = 1'b1; data_addr = 32'd8; data_out = 32'd36;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 6'd11;
        #1;
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL prio_ready got=%b exp=0", host_ready); end
        tick();
        mem_write = 1'b0;
        #1;
        total++; if (wr_count !== 16'd2) begin bad++; $display("FAIL prio_count got=%0d exp=2", wr_count); end
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL prio_ready2 got=%b exp=1", host_ready); end
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL prio_no_accept got=%b exp=0", host_rvalid); end
        tick();
        host_valid = 1'b0;
        #1;
        total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL prio_rvalid got=%b exp=1", host_rvalid); end
        total++; if (host_rdata !== 32'd12) begin bad++; $display("FAIL prio_rdata got=%0d exp=12", host_rdata); end
        tick();
    endtask

    task automatic test_host_read();
        host_valid = 1'b1; host_we = 1'b0; host_addr = 6'd2;
        tick();
        host_valid = 1'b0;
        #1;
        total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL hr_rvalid got=%b exp=1", host_rvalid); end
        total++; if (host_rdata !== 32'd36) begin bad++; $display("FAIL hr_rdata got=%0d exp=36", host_rdata); end
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL hr_ready got=%b exp=0", host_ready); end
        tick();
        #1;
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL hr_pulse got=%b exp=0", host_rvalid); end
        total++; if (host_rdata !== 32'd36) begin bad++; $display("FAIL hr_hold got=%0d exp=36", host_rdata); end
    endtask

    task automatic test_back_to_back();
        host_valid = 1'b1; host_we = 1'b1; host_addr = 6'd20; host_wdata = 32'hA5;
        tick();
        // Next request presented during RESP; it must wait one cycle
        host_we = 1'b0;
        #1;
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL b2b_resp_ready got=%b exp=0", host_ready); end
        tick();
        #1;
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_early got=%b exp=0", host_rvalid); end
        tick();
        host_valid = 1'b0;
        #1;
        total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid got=%b exp=1", host_rvalid); end
        total++; if (host_rdata !== 32'hA5) begin bad++; $display("FAIL b2b_rdata got=%h exp=a5", host_rdata); end
        total++; if (wr_count !== 16'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", wr_count); end
        tick();
    endtask

    task automatic test_addr_err();
        mem_write = 1'b1; data_addr = 32'd4; data_out = 32'h44;
        tick();
        data_addr = 32'd0; data_out = 32'h55;
        tick();
        data_addr = 32'd6; data_out = 32'h999;
        #1;
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL ae_pre got=%b exp=0", addr_err); end
        tick();
        mem_write = 1'b0;
        #1;
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL ae_set got=%b exp=1", addr_err); end
        total++; if (wr_count !== 16'd5) begin bad++; $display("FAIL ae_count1 got=%0d exp=5", wr_count); end
        mem_read = 1'b1; data_addr = 32'd4;
        #1;
        total++; if (data_in !== 32'h44) begin bad++; $display("FAIL ae_ram4 got=%h exp=44", data_in); end
        mem_read = 1'b0; mem_write = 1'b1; data_addr = 32'd256; data_out = 32'hDEAD;
        tick();
        mem_write = 1'b0; mem_read = 1'b1;
        #1;
        total++; if (data_in !== 32'd0) begin bad++; $display("FAIL ae_illegal_load got=%h exp=0", data_in); end
        data_addr = 32'd0;
        #1;
        total++; if (data_in !== 32'h55) begin bad++; $display("FAIL ae_ram0 got=%h exp=55", data_in); end
        mem_read = 1'b0;
        tick();
        tick();
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL ae_sticky got=%b exp=1", addr_err); end
        total++; if (wr_count !== 16'd5) begin bad++; $display("FAIL ae_count2 got=%0d exp=5", wr_count); end
    endtask

    task automatic test_reset_in_resp();
        host_valid = 1'b1; host_we = 1'b0; host_addr = 6'd2;
        tick();
        host_valid = 1'b0;
        #1;
        total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL rr_rvalid got=%b exp=1", host_rvalid); end
        rst = 1'b1;
        #1;
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rr_drop got=%b exp=0", host_rvalid); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL rr_addr_err got=%b exp=0", addr_err); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL rr_count got=%0d exp=0", wr_count); end
        total++; if (host_rdata !== 32'd0) begin bad++; $display("FAIL rr_rdata got=%h exp=0", host_rdata); end
        // Store attempted under reset must not land
        mem_write = 1'b1; data_addr = 32'd8; data_out = 32'hBAD;
        tick();
        mem_write = 1'b0; mem_read = 1'b1;
        #1;
        total++; if (data_in !== 32'd36) begin bad++; $display("FAIL rr_comb_load got=%0d exp=36", data_in); end
        mem_read = 1'b0;
        rst = 1'b0;
        tick();
        #1;
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL rr_idle got=%b exp=1", host_ready); end
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rr_after got=%b exp=0", host_rvalid); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL rr_count2 got=%0d exp=0", wr_count); end
        mem_read = 1'b1; data_addr = 32'd44;
        #1;
        total++; if (data_in !== 32'd12) begin bad++; $display("FAIL rr_ram_kept got=%0d exp=12", data_in); end
        mem_read = 1'b0;
    endtask

    task automatic test_saturate();
        mem_write = 1'b1; data_addr = 32'd12;
        for (int i = 0; i < 65534; i++) begin
            data_out = i;
            tick();
        end
        total++; if (wr_count !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe got=%h exp=fffe", wr_count); end
        tick();
        total++; if (wr_count !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff got=%h exp=ffff", wr_count); end
        data_out = 32'h1234;
        tick();
        mem_write = 1'b0;
        #1;
        total++; if (wr_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", wr_count); end
        mem_read = 1'b1;
        #1;
        total++; if (data_in !== 32'h1234) begin bad++; $display("FAIL sat_data got=%h exp=1234", data_in); end
        mem_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_cpu_priority();
        test_host_read();
        test_back_to_back();
        test_addr_err();
        test_reset_in_resp();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
